// File: rtl/enc_capture_ctrl.sv
// Encoder edge capture: synchroniser and glitch filter on enc_in, timestamped edge records in a
// first-word-fall-through FIFO streamed over AXI-Stream, with start/stop/drain run control.
module enc_capture_ctrl #(
    parameter int unsigned TS_WIDTH      = 48,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned GLITCH_CYCLES = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          enc_in,
    input  logic                          ctrl_start,
    input  logic                          ctrl_stop,
    input  logic                          ctrl_clear,
    output logic [63:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [1:0]                    state,
    output logic [31:0]                   edge_count,
    output logic [31:0]                   overflow_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(GLITCH_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StRun   = 2'd2,
        StDrain = 2'd3
    } state_e;

    state_e                 state_q;
    logic [CntW-1:0]        arm_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q;
    logic [CntW-1:0]        stab_q;
    logic [TS_WIDTH-1:0]    ts_q;
    logic [14:0]            seq_q;
    logic [31:0]            edge_cnt_q, ovf_cnt_q;
    logic [63:0]            mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]        level_q, level_d;
    logic [63:0]            tdata_q, tdata_d, record;
    logic                   tvalid_q, tvalid_d;
    logic                   sync_lvl, toggle, clr_idle, run_edge, full, pop, push, drop;

    always_comb begin
        sync_lvl = sync_q[SYNC_STAGES-1];
        toggle   = (sync_lvl != filt_q) && (stab_q == CntW'(GLITCH_CYCLES - 1));
        clr_idle = ctrl_clear && (state_q == StIdle);
        run_edge = toggle && (state_q == StRun);
        full     = (level_q == LvlW'(FIFO_DEPTH));
        pop      = tvalid_q && m_axis_tready;
        // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
        push     = run_edge && (!full || pop);
        drop     = run_edge && full && !pop;
        record   = {~filt_q, seq_q, 48'(ts_q)};
    end

    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        tvalid_d = (level_d != '0);
        tdata_d  = tdata_q;
        // Head slot being written this cycle must bypass the memory.
        if (tvalid_d) begin
            tdata_d = (push && (wr_ptr_q == rd_ptr_d)) ? record : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= record;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q     <= '0;
            filt_q     <= 1'b0;
            stab_q     <= '0;
            ts_q       <= '0;
            seq_q      <= '0;
            edge_cnt_q <= '0;
            ovf_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], enc_in};
            if ((sync_lvl == filt_q) || toggle) begin
                stab_q <= '0;
            end else begin
                stab_q <= stab_q + 1'b1;
            end
            if (toggle) begin
                filt_q <= ~filt_q;
            end
            ts_q <= clr_idle ? '0 : ts_q + 1'b1;
            if (clr_idle) begin
                seq_q      <= '0;
                edge_cnt_q <= '0;
                ovf_cnt_q  <= '0;
            end else begin
                if (run_edge) begin
                    seq_q <= seq_q + 1'b1;
                end
                if (push && (edge_cnt_q != '1)) begin
                    edge_cnt_q <= edge_cnt_q + 1'b1;
                end
                if (drop && (ovf_cnt_q != '1)) begin
                    ovf_cnt_q <= ovf_cnt_q + 1'b1;
                end
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

    // Run control; ARMED waits out the filter so a pre-start transition is never recorded.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            arm_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    arm_q <= '0;
                    if (ctrl_start && !ctrl_stop) begin
                        state_q <= StArmed;
                    end
                end
                StArmed: begin
                    if (ctrl_stop) begin
                        state_q <= StIdle;
                    end else if (arm_q == CntW'(GLITCH_CYCLES - 1)) begin
                        state_q <= StRun;
                    end else begin
                        arm_q <= arm_q + 1'b1;
                    end
                end
                StRun: begin
                    if (ctrl_stop) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (level_q == '0) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_axis_tdata   = tdata_q;
    assign m_axis_tvalid  = tvalid_q;
    assign state          = state_q;
    assign edge_count     = edge_cnt_q;
    assign overflow_count = ovf_cnt_q;
    assign fifo_level     = level_q;
endmodule

// File: tb/tb_enc_capture_ctrl.sv
// Directed bench for enc_capture_ctrl: run-control vector table plus hand sequences for capture,
// glitch rejection, backpressure/overflow, drain, async reset and timestamp wrap.
module tb_enc_capture_ctrl;
    localparam int unsigned S = 2;
    localparam int unsigned G = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enc_in = 1'b0, ctrl_start = 1'b0, ctrl_stop = 1'b0, ctrl_clear = 1'b0;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic [1:0]  state;
    logic [31:0] edge_count, overflow_count;
    logic [4:0]  fifo_level;

    logic        enc2 = 1'b0, start2 = 1'b0;
    logic [63:0] tdata2;
    logic        tvalid2;
    logic [1:0]  state2;
    logic [31:0] ec2, oc2;
    logic [2:0]  lvl2;

    enc_capture_ctrl dut (
        .aclk(aclk), .aresetn(aresetn), .enc_in(enc_in), .ctrl_start(ctrl_start),
        .ctrl_stop(ctrl_stop), .ctrl_clear(ctrl_clear), .m_axis_tdata(tdata),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .state(state), .edge_count(edge_count),
        .overflow_count(overflow_count), .fifo_level(fifo_level)
    );

    enc_capture_ctrl #(.TS_WIDTH(8), .FIFO_DEPTH(4), .SYNC_STAGES(2), .GLITCH_CYCLES(1)) dut_wrap (
        .aclk(aclk), .aresetn(aresetn), .enc_in(enc2), .ctrl_start(start2), .ctrl_stop(1'b0),
        .ctrl_clear(1'b0), .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(1'b1),
        .state(state2), .edge_count(ec2), .overflow_count(oc2), .fifo_level(lvl2)
    );

    always #5 aclk = ~aclk;

    // Reference timestamp: counts from reset release, zeroed when the bench issues an idle clear.
    logic [47:0] ts_model;
    logic        ts_clr = 1'b0;
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn)    ts_model <= '0;
        else if (ts_clr) ts_model <= '0;
        else             ts_model <= ts_model + 1'b1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_rng(input string name, input logic [63:0] got, input logic [63:0] lo,
                             input logic [63:0] hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h..0x%0h", name, got, lo, hi);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic p, input logic c);
        ctrl_start = s; ctrl_stop = p; ctrl_clear = c;
        tick(1);
        ctrl_start = 1'b0; ctrl_stop = 1'b0; ctrl_clear = 1'b0;
    endtask

    logic [63:0] rx_q[$];
    logic [63:0] rx2_q[$];
    logic [63:0] hold_d;
    bit          hold_v = 1'b0;

    initial forever begin
        @(negedge aclk);
        if (aresetn && tvalid && !tready) begin
            if (hold_v) check("stall_stable", tdata, hold_d);
            hold_d = tdata;
            hold_v = 1'b1;
        end else begin
            hold_v = 1'b0;
        end
        if (aresetn && tvalid && tready) rx_q.push_back(tdata);
        if (aresetn && tvalid2) rx2_q.push_back(tdata2);
    end

    function automatic logic [63:0] take();
        if (rx_q.size() == 0) return '0;
        return rx_q.pop_front();
    endfunction

    task automatic wait_state(input logic [1:0] st, input int budget, input string name);
        for (int i = 0; i < budget && state !== st; i++) tick(1);
        check(name, state, st);
    endtask

    task automatic wait_rx(input int n, input int budget, input string name);
        for (int i = 0; i < budget && rx_q.size() < n; i++) tick(1);
        check(name, rx_q.size(), n);
    endtask

    typedef struct {
        logic       start;
        logic       stop;
        logic       clear;
        logic [1:0] st;
    } vec_t;
    vec_t vecs[14];

    initial begin
        logic [63:0] r;
        logic [47:0] t0;
        logic [7:0]  nx;
        int          found;

        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] r;
        logic [47:0] t0;
        logic [7:0]  nx;
        int          found;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd2};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd2};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'd2};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'd3};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2'd1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 2'd0};

        tick(3);
        check("rst_tdata", tdata, 64'd0);
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_state", state, 2'd0);
        check("rst_edges", edge_count, 32'd0);
        check("rst_ovf", overflow_count, 32'd0);
        check("rst_level", fifo_level, 5'd0);
        aresetn = 1'b1;
        tick(2);

        for (int i = 0; i < 14; i++) begin
            pulse(vecs[i].start, vecs[i].stop, vecs[i].clear);
            check($sformatf("vec%0d_state", i), state, vecs[i].st);
        end

        aresetn = 1'b0;
        tick(1);
        aresetn = 1'b1;
        tick(2);

        // First capture
        pulse(1'b1, 1'b0, 1'b0);
        wait_state(2'd2, 10, "t1_run");
        t0 = ts_model;
        enc_in = 1'b1;
        wait_rx(1, 30, "t1_rx");
        r = take();
        check("t1_pol", r[63], 1'b1);
        check("t1_seq", r[62:48], 15'd0);
        check_rng("t1_ts", r[47:0], t0 + S + G - 1, t0 + S + G + 1);
        check("t1_edges", edge_count, 32'd1);
        enc_in = 1'b0;
        wait_rx(1, 30, "t1_fall_rx");
        r = take();
        check("t1_fall_pol", r[63], 1'b0);
        check("t1_fall_seq", r[62:48], 15'd1);

        // Glitch rejection
        enc_in = 1'b1;
        tick(3);
        enc_in = 1'b0;
        tick(20);
        check("glitch_rx", rx_q.size(), 0);
        check("glitch_edges", edge_count, 32'd2);
        enc_in = 1'b1;
        tick(4);
        enc_in = 1'b0;
        wait_rx(1, 30, "glitch4_rx");
        r = take();
        check("glitch4_pol", r[63], 1'b1);
        check("glitch4_seq", r[62:48], 15'd2);
        wait_rx(1, 30, "glitch4_fall_rx");
        r = take();
        check("glitch4_edges", edge_count, 32'd4);

        // Clear honoured in IDLE
        pulse(1'b0, 1'b1, 1'b0);
        wait_state(2'd0, 10, "clr_idle_state");
        ctrl_clear = 1'b1; ts_clr = 1'b1;
        tick(1);
        ctrl_clear = 1'b0; ts_clr = 1'b0;
        check("clr_edges", edge_count, 32'd0);
        check("clr_ovf", overflow_count, 32'd0);

        // Backpressure and overflow
        tready = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        wait_state(2'd2, 10, "bp_run");
        t0 = ts_model;
        for (int i = 0; i < 20; i++) begin
            enc_in = ~enc_in;
            tick(10);
        end
        tick(10);
        check("bp_level", fifo_level, 5'd16);
        check("bp_ovf", overflow_count, 32'd4);
        check("bp_edges", edge_count, 32'd16);
        pulse(1'b0, 1'b0, 1'b1);
        check("run_clr_edges", edge_count, 32'd16);
        check("run_clr_ovf", overflow_count, 32'd4);
        check("run_clr_level", fifo_level, 5'd16);
        check("run_clr_state", state, 2'd2);
        tready = 1'b1;
        wait_rx(16, 60, "bp_rx");
        for (int i = 0; i < 16; i++) begin
            r = take();
            check($sformatf("bp_seq%0d", i), r[62:48], 15'(i));
            check($sformatf("bp_pol%0d", i), r[63], (i % 2) == 0);
            if (i == 0) check_rng("bp_ts0", r[47:0], t0 + S + G - 1, t0 + S + G + 1);
        end
        enc_in = 1'b1;
        wait_rx(1, 30, "gap_rx");
        r = take();
        check("gap_seq", r[62:48], 15'd20);
        check("gap_pol", r[63], 1'b1);

        // Stop with records queued, edge during drain
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enc_in = ~enc_in;
            tick(10);
        end
        check("drain_level", fifo_level, 5'd5);
        pulse(1'b0, 1'b1, 1'b0);
        check("drain_state", state, 2'd3);
        enc_in = ~enc_in;
        tick(15);
        check("drain_edge_level", fifo_level, 5'd5);
        check("drain_edge_count", edge_count, 32'd22);
        tready = 1'b1;
        wait_rx(5, 20, "drain_rx");
        wait_state(2'd0, 5, "drain_idle");
        for (int i = 0; i < 5; i++) begin
            r = take();
            check($sformatf("drain_seq%0d", i), r[62:48], 15'(21 + i));
        end
        tick(5);
        check("drain_no_extra", rx_q.size(), 0);

        // Async reset mid-RUN
        tready = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        wait_state(2'd2, 10, "ar_run");
        for (int i = 0; i < 3; i++) begin
            enc_in = ~enc_in;
            tick(10);
        end
        tick(5);
        check("ar_level_pre", fifo_level, 5'd3);
        check("ar_tvalid_pre", tvalid, 1'b1);
        #3 aresetn = 1'b0;
        #1;
        check("ar_tvalid", tvalid, 1'b0);
        check("ar_level", fifo_level, 5'd0);
        check("ar_state", state, 2'd0);
        tick(1);
        aresetn = 1'b1;
        tready = 1'b1;
        tick(2);
        rx_q.delete();
        rx2_q.delete();

        // Timestamp wrap on an 8-bit instance with single-cycle filter
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        for (int i = 0; i < 10 && state2 !== 2'd2; i++) tick(1);
        check("wrap_run", state2, 2'd2);
        for (int i = 0; i < 300; i++) begin
            enc2 = ~enc2;
            tick(1);
        end
        tick(5);
        check_rng("wrap_count", rx2_q.size(), 290, 300);
        found = 0;
        for (int i = 1; i < rx2_q.size(); i++) begin
            nx = rx2_q[i-1][7:0] + 8'd1;
            check($sformatf("wrap_step%0d", i), rx2_q[i][47:0], {40'd0, nx});
            if (rx2_q[i-1][47:0] == 48'd255) begin
                found++;
                check("wrap_255_to_0", rx2_q[i][47:0], 48'd0);
            end
        end
        check("wrap_seen", found != 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/enc_capture_ctrl.md
Name: enc_capture_ctrl

Overview:
- Sequences encoder edge capture for the PL datapath fed by the top-level `enc_in` pin.
- Synchronises and glitch-filters `enc_in`, then timestamps every filtered edge against a free-running counter.
- Buffers the records in a small FIFO and streams them to the DMA/AXI-Stream path.
- A run-control FSM (start/stop/drain) gates capture and keeps overflow/edge statistics for the PS.

Parameters:
- TS_WIDTH, 48, timestamp counter width; wraps modulo 2^TS_WIDTH.
- FIFO_DEPTH, 16, record buffer depth (power of 2, ≥2).
- SYNC_STAGES, 2, flip-flop synchroniser stages on `enc_in` (≥2).
- GLITCH_CYCLES, 4, consecutive stable cycles required to accept a level change (≥1).

Ports:
- aclk  in  1  sole clock.
- aresetn  in  1  asynchronous, active-low reset.
- enc_in  in  1  raw asynchronous encoder input.
- ctrl_start  in  1  one-cycle pulse: begin capture.
- ctrl_stop  in  1  one-cycle pulse: end capture.
- ctrl_clear  in  1  one-cycle pulse: zero timestamp and statistics (honoured only in IDLE).
- m_axis_tdata  out  64  [63]=edge polarity (1=rising), [62:48]=15-bit sequence number, [47:0]=timestamp (zero-extended if TS_WIDTH<48).
- m_axis_tvalid  out  1  record valid.
- m_axis_tready  in  1  downstream ready.
- state  out  2  0=IDLE, 1=ARMED, 2=RUN, 3=DRAIN.
- edge_count  out  32  accepted edges (saturating).
- overflow_count  out  32  edges dropped on full FIFO (saturating).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (aresetn=0, async):
  - All outputs 0; FIFO empty; state IDLE; timestamp 0; sequence 0.
  - Filtered level and synchroniser chain 0.
  - Applies mid-operation: pending records are discarded.
- Timestamp counter increments every cycle from reset release and wraps to 0 after all-ones. ctrl_clear in IDLE zeroes it the next cycle.
- Filter:
  - sync = `enc_in` after SYNC_STAGES flops.
  - Stability counter counts cycles with sync≠filt.
  - When it reaches GLITCH_CYCLES, filt toggles and the counter resets.
  - Any cycle with sync==filt resets the counter.
  - Latency from `enc_in` change to filt change: SYNC_STAGES+GLITCH_CYCLES cycles.
  - A filt toggle is an edge; polarity = new filt value.
- FSM:
  - IDLE: ctrl_start → ARMED.
  - ARMED: filter runs; edges are ignored. After GLITCH_CYCLES cycles in ARMED → RUN, so a stale pre-start transition is never captured. ctrl_stop → IDLE.
  - RUN: each edge is written to the FIFO in the same cycle filt toggles, with timestamp = counter value that cycle. ctrl_stop → DRAIN.
  - DRAIN: no new writes. When FIFO is empty → IDLE. ctrl_start ignored.
  - ctrl_start and ctrl_stop in the same cycle: stop wins.
  - ctrl_clear outside IDLE is ignored.
- Edge write in RUN:
  - FIFO not full: write the record; edge_count+1; sequence+1 (15-bit wrap).
  - FIFO full: drop the record; overflow_count+1; sequence still +1, so gaps are visible downstream.
  - Both counters saturate at 0xFFFFFFFF.
- ctrl_clear in IDLE zeroes edge_count, overflow_count, sequence and timestamp. FIFO contents are unaffected; FIFO is already empty in IDLE.
- FIFO / stream:
  - First-word-fall-through: tvalid rises the cycle after the write.
  - tdata is held stable while tvalid=1 and tready=0.
  - Pop occurs on tvalid&tready.
  - Simultaneous push and pop when full: the push is accepted, because the pop frees a slot the same cycle. fifo_level is unchanged.
  - Empty: tvalid=0, tdata holds its last value.
- All outputs are registered.

Test Plan:
- Reset, start, `enc_in` rises at cycle T, tready=1 → state RUN; one record with tdata[63]=1, seq=0, timestamp = counter at T+SYNC_STAGES+GLITCH_CYCLES (±1 for async sampling); edge_count=1.
- Glitch: `enc_in` high for 3 cycles (GLITCH_CYCLES=4) in RUN → no record, edge_count unchanged. Then high for 4 cycles → one rising record.
- Backpressure: tready=0, 20 alternating edges spaced 10 cycles apart → fifo_level=16, overflow_count=4, edge_count=16. Release tready → 16 records with seq 0..15 in order and tdata stable during stall; next accepted edge carries seq=20.
- Stop with 5 records queued → state DRAIN; after 5 handshakes, state IDLE. An edge during DRAIN produces no record.
- ctrl_start and ctrl_stop pulsed together from RUN → DRAIN. ctrl_clear in RUN → counters unchanged. ctrl_clear in IDLE → counters and timestamp zeroed next cycle.
- aresetn asserted asynchronously mid-RUN with 3 records queued → tvalid=0, fifo_level=0, state IDLE immediately. Timestamp wrap with TS_WIDTH=8 → timestamp 255 followed by 0.
